// File: rtl/niosii_system_sysid_checker_if.sv
// Avalon-MM style bundle used for both the sysid master link and the CPU-facing slave.
// The same interface type serves both sides; only the address width differs.
interface niosii_system_sysid_checker_if #(
    parameter int unsigned AddrWidth = 1
);
    logic [AddrWidth-1:0] address;
    logic                 read;
    logic                 write;
    logic [31:0]          writedata;
    logic [31:0]          readdata;

    modport master (
        output address, read, write, writedata,
        input  readdata
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata
    );
endinterface

// File: rtl/niosii_system_sysid_checker.sv
// Boot-time sysid verifier: reads ID and timestamp words, compares them with build-time
// values, retries on mismatch and reports the verdict over a small register slave.
module niosii_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID  = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS  = 32'h588D_0377,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned MAX_RETRY    = 3,
    parameter bit          AUTO_START   = 1'b1
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    niosii_system_sysid_checker_if.master        m,
    niosii_system_sysid_checker_if.slave         s,
    output logic                                 sysid_ok
);

    typedef enum logic [2:0] {
        StIdle,
        StIssueId,
        StWaitId,
        StIssueTs,
        StWaitTs,
        StCmp,
        StDone
    } state_e;

    // The ISSUE cycle already counts as one latency cycle, hence the minus one.
    localparam logic [2:0] LatInit  = 3'((READ_LATENCY == 0) ? 0 : READ_LATENCY - 1);
    localparam logic [3:0] MaxRetry = 4'(MAX_RETRY);

    state_e      state_q, state_d;
    logic [2:0]  lat_q, lat_d;
    logic [31:0] cap_id_q, cap_id_d;
    logic [31:0] cap_ts_q, cap_ts_d;
    logic [3:0]  retries_q, retries_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        m_read_q, m_read_d;
    logic        m_address_q, m_address_d;
    logic [31:0] s_readdata_q, s_readdata_d;
    logic        sysid_ok_q, sysid_ok_d;

    logic        restart;
    logic        busy;
    logic [31:0] status;

    assign busy    = (state_q != StIdle) && (state_q != StDone);
    assign status  = {24'b0, retries_q, 1'b0, busy, pass_q, done_q};
    assign restart = s.write && (s.address == 2'd3) && s.writedata[0] && !busy;

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        cap_id_d  = cap_id_q;
        cap_ts_d  = cap_ts_q;
        retries_d = retries_q;
        done_d    = done_q;
        pass_d    = pass_q;

        unique case (state_q)
            StIdle: begin
                if (AUTO_START || restart) begin
                    retries_d = 4'd0;
                    state_d   = StIssueId;
                end
            end
            StIssueId: begin
                if (READ_LATENCY == 0) begin
                    cap_id_d = m.readdata;
                    state_d  = StIssueTs;
                end else begin
                    lat_d   = LatInit;
                    state_d = StWaitId;
                end
            end
            StWaitId: begin
                if (lat_q == 3'd0) begin
                    cap_id_d = m.readdata;
                    state_d  = StIssueTs;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            StIssueTs: begin
                if (READ_LATENCY == 0) begin
                    cap_ts_d = m.readdata;
                    state_d  = StCmp;
                end else begin
                    lat_d   = LatInit;
                    state_d = StWaitTs;
                end
            end
            StWaitTs: begin
                if (lat_q == 3'd0) begin
                    cap_ts_d = m.readdata;
                    state_d  = StCmp;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            StCmp: begin
                if ((cap_id_q == EXPECTED_ID) && (cap_ts_q == EXPECTED_TS)) begin
                    done_d  = 1'b1;
                    pass_d  = 1'b1;
                    state_d = StDone;
                end else if (retries_q < MaxRetry) begin
                    retries_d = retries_q + 4'd1;
                    state_d   = StIssueId;
                end else begin
                    done_d  = 1'b1;
                    pass_d  = 1'b0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (restart) begin
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    retries_d = 4'd0;
                    state_d   = StIssueId;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are computed from next-state so they leave the flops aligned with the state.
    always_comb begin
        m_read_d     = (state_d == StIssueId) || (state_d == StIssueTs);
        m_address_d  = (state_d == StIssueTs);
        sysid_ok_d   = done_d && pass_d;
        s_readdata_d = s_readdata_q;
        if (s.read) begin
            unique case (s.address)
                2'd0:    s_readdata_d = status;
                2'd1:    s_readdata_d = cap_id_q;
                2'd2:    s_readdata_d = cap_ts_q;
                default: s_readdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            lat_q        <= 3'd0;
            cap_id_q     <= 32'd0;
            cap_ts_q     <= 32'd0;
            retries_q    <= 4'd0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            m_read_q     <= 1'b0;
            m_address_q  <= 1'b0;
            s_readdata_q <= 32'd0;
            sysid_ok_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            cap_id_q     <= cap_id_d;
            cap_ts_q     <= cap_ts_d;
            retries_q    <= retries_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            m_read_q     <= m_read_d;
            m_address_q  <= m_address_d;
            s_readdata_q <= s_readdata_d;
            sysid_ok_q   <= sysid_ok_d;
        end
    end

    assign m.address   = m_address_q;
    assign m.read      = m_read_q;
    assign m.write     = 1'b0;
    assign m.writedata = 32'd0;
    assign s.readdata  = s_readdata_q;
    assign sysid_ok    = sysid_ok_q;

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Bench for the sysid checker: three instances (latency 1, 0, 7) each driven by a timed
// sysid responder; outcomes are predicted from the pass/retry rules and cycle formulas.
module tb_niosii_system_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'h588D_0377;
    localparam int          MAXR   = 3;

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 0 : 7);
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n  [3];
    logic        s_rd   [3];
    logic        s_wr   [3];
    logic [1:0]  s_addr [3];
    logic [31:0] s_wd   [3];
    logic [31:0] rdata  [3];
    logic        mrd    [3];
    logic        madr   [3];
    logic        ok     [3];
    logic [31:0] m_rdata[3];

    // Responder / monitor state, written only by the model process below.
    int          cyc     [3];
    int          rd_n    [3];
    int          rd_cyc  [3][16];
    logic        rd_adr  [3][16];
    int          ok_cyc  [3];
    int          id_cnt  [3];
    int          ts_cnt  [3];
    logic        pend_v  [3];
    int          pend_due[3];
    logic [31:0] pend_val[3];

    // Per-pass responses; passes beyond n_resp return the expected words.
    logic [31:0] id_resp[3][8];
    logic [31:0] ts_resp[3][8];
    int          n_resp [3];

    int n_cmp  = 0;
    int n_fail = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned L = (g == 0) ? 1 : ((g == 1) ? 0 : 7);
        niosii_system_sysid_checker_if #(.AddrWidth(1)) mb ();
        niosii_system_sysid_checker_if #(.AddrWidth(2)) sb ();
        assign mb.readdata  = m_rdata[g];
        assign sb.address   = s_addr[g];
        assign sb.read      = s_rd[g];
        assign sb.write     = s_wr[g];
        assign sb.writedata = s_wd[g];
        assign mrd[g]       = mb.read;
        assign madr[g]      = mb.address[0];
        assign rdata[g]     = sb.readdata;

        niosii_system_sysid_checker #(
            .EXPECTED_ID (EXP_ID),
            .EXPECTED_TS (EXP_TS),
            .READ_LATENCY(L),
            .MAX_RETRY   (MAXR),
            .AUTO_START  (1'b1)
        ) u_dut (
            .clock   (clk),
            .reset_n (rst_n[g]),
            .m       (mb),
            .s       (sb),
            .sysid_ok(ok[g])
        );
    end

    // Sysid responder: data is valid only in the cycle issue+L, random garbage otherwise.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (!rst_n[g]) begin
                cyc[g]     = -1;
                rd_n[g]    = 0;
                ok_cyc[g]  = -1;
                id_cnt[g]  = 0;
                ts_cnt[g]  = 0;
                pend_v[g]  = 1'b0;
                m_rdata[g] = $urandom;
            end else begin
                cyc[g]++;
                if (mrd[g]) begin
                    if (rd_n[g] < 16) begin
                        rd_cyc[g][rd_n[g]] = cyc[g];
                        rd_adr[g][rd_n[g]] = madr[g];
                    end
                    rd_n[g]++;
                    pend_v[g]   = 1'b1;
                    pend_due[g] = cyc[g] + lat_of(g);
                    if (madr[g]) begin
                        pend_val[g] = (ts_cnt[g] < n_resp[g]) ? ts_resp[g][ts_cnt[g]] : EXP_TS;
                        ts_cnt[g]++;
                    end else begin
                        pend_val[g] = (id_cnt[g] < n_resp[g]) ? id_resp[g][id_cnt[g]] : EXP_ID;
                        id_cnt[g]++;
                    end
                end
                if (pend_v[g] && pend_due[g] == cyc[g]) begin
                    m_rdata[g] = pend_val[g];
                    pend_v[g]  = 1'b0;
                end else begin
                    m_rdata[g] = $urandom;
                end
                if (ok[g] && ok_cyc[g] < 0) ok_cyc[g] = cyc[g];
            end
        end
    end

    // Reference: first pass whose words both match wins; otherwise MAX_RETRY passes are spent.
    task automatic predict(input int g, output int retr, output bit pass, output int done_c,
                           output logic [31:0] cid, output logic [31:0] cts);
        int L;
        L    = lat_of(g);
        pass = 1'b0;
        retr = MAXR;
        cid  = 32'd0;
        cts  = 32'd0;
        for (int p = 0; p <= MAXR; p++) begin
            cid = (p < n_resp[g]) ? id_resp[g][p] : EXP_ID;
            cts = (p < n_resp[g]) ? ts_resp[g][p] : EXP_TS;
            if (cid == EXP_ID && cts == EXP_TS) begin
                pass = 1'b1;
                retr = p;
                break;
            end
        end
        done_c = 4 + 2 * L + retr * (3 + 2 * L);
    endtask

    // Leaves the caller at posedge+1 of cycle 0.
    task automatic start(input int g);
        rst_n[g] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n[g] = 1'b1;
    endtask

    task automatic wait_until(input int g, input int c);
        for (int i = 0; i < 400 && cyc[g] + 1 < c; i++) begin
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (cyc[g] + 1 != c) begin
            n_fail++;
            $display("FAIL wait_cycle dut%0d: at %0d want %0d", g, cyc[g] + 1, c);
        end
    endtask

    task automatic slave_read(input int g, input logic [1:0] a, output logic [31:0] d);
        s_rd[g]   = 1'b1;
        s_addr[g] = a;
        @(posedge clk);
        #1;
        s_rd[g] = 1'b0;
        d       = rdata[g];
    endtask

    task automatic slave_write(input int g, input logic [1:0] a, input logic [31:0] d);
        s_wr[g]   = 1'b1;
        s_addr[g] = a;
        s_wd[g]   = d;
        @(posedge clk);
        #1;
        s_wr[g] = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            n_cmp += 4;
            if (mrd[g] !== 1'b0) begin
                n_fail++; $display("FAIL reset_m_read dut%0d: got %b want 0", g, mrd[g]);
            end
            if (madr[g] !== 1'b0) begin
                n_fail++; $display("FAIL reset_m_address dut%0d: got %b want 0", g, madr[g]);
            end
            if (rdata[g] !== 32'd0) begin
                n_fail++; $display("FAIL reset_s_readdata dut%0d: got %h want 0", g, rdata[g]);
            end
            if (ok[g] !== 1'b0) begin
                n_fail++; $display("FAIL reset_sysid_ok dut%0d: got %b want 0", g, ok[g]);
            end
        end
    endtask

    // Clean first pass on every latency; read cycles and done cycle follow 1, 2+L, 4+2L.
    task automatic test_first_pass();
        logic [31:0] d;
        for (int g = 0; g < 3; g++) begin
            int L;
            L         = lat_of(g);
            n_resp[g] = 0;
            start(g);
            wait_until(g, 4 + 2 * L + 2);
            slave_read(g, 2'd0, d);
            n_cmp += 7;
            if (d !== 32'h3) begin
                n_fail++; $display("FAIL first_status dut%0d: got %h want 3", g, d);
            end
            if (rd_n[g] != 2) begin
                n_fail++; $display("FAIL first_reads dut%0d: got %0d want 2", g, rd_n[g]);
            end
            if (rd_cyc[g][0] != 1 || rd_adr[g][0] !== 1'b0) begin
                n_fail++;
                $display("FAIL first_id_read dut%0d: got cyc %0d adr %b want 1/0", g,
                         rd_cyc[g][0], rd_adr[g][0]);
            end
            if (rd_cyc[g][1] != 2 + L || rd_adr[g][1] !== 1'b1) begin
                n_fail++;
                $display("FAIL first_ts_read dut%0d: got cyc %0d adr %b want %0d/1", g,
                         rd_cyc[g][1], rd_adr[g][1], 2 + L);
            end
            if (ok_cyc[g] != 4 + 2 * L) begin
                n_fail++; $display("FAIL first_ok_cycle dut%0d: got %0d want %0d", g, ok_cyc[g],
                                   4 + 2 * L);
            end
            slave_read(g, 2'd1, d);
            if (d !== EXP_ID) begin
                n_fail++; $display("FAIL first_cap_id dut%0d: got %h want %h", g, d, EXP_ID);
            end
            slave_read(g, 2'd2, d);
            if (d !== EXP_TS) begin
                n_fail++; $display("FAIL first_cap_ts dut%0d: got %h want %h", g, d, EXP_TS);
            end
        end
    endtask

    task automatic test_retry_exhaust();
        logic [31:0] d;
        n_resp[0] = 4;
        for (int p = 0; p < 4; p++) begin
            id_resp[0][p] = EXP_ID;
            ts_resp[0][p] = EXP_TS ^ ($urandom | 32'h1);
        end
        ts_resp[0][3] = 32'h1234_5678;
        start(0);
        wait_until(0, 4 + 2 + 3 * 5 + 3);
        slave_read(0, 2'd0, d);
        n_cmp += 6;
        if (d !== 32'h31) begin
            n_fail++; $display("FAIL exhaust_status: got %h want 31", d);
        end
        if (ok[0] !== 1'b0 || ok_cyc[0] != -1) begin
            n_fail++; $display("FAIL exhaust_sysid_ok: got %b (first %0d) want 0", ok[0], ok_cyc[0]);
        end
        if (rd_n[0] != 8) begin
            n_fail++; $display("FAIL exhaust_reads: got %0d want 8", rd_n[0]);
        end
        if (rd_cyc[0][6] != 16) begin
            n_fail++; $display("FAIL exhaust_last_pass_cycle: got %0d want 16", rd_cyc[0][6]);
        end
        slave_read(0, 2'd2, d);
        if (d !== 32'h1234_5678) begin
            n_fail++; $display("FAIL exhaust_cap_ts: got %h want 12345678", d);
        end
        slave_read(0, 2'd3, d);
        if (d !== 32'd0) begin
            n_fail++; $display("FAIL ctrl_readback: got %h want 0", d);
        end
        n_resp[0] = 0;
    endtask

    task automatic test_one_retry();
        logic [31:0] d;
        n_resp[0]     = 1;
        id_resp[0][0] = EXP_ID | ($urandom | 32'h1);
        ts_resp[0][0] = EXP_TS;
        start(0);
        wait_until(0, 13);
        slave_read(0, 2'd0, d);
        n_cmp += 3;
        if (d !== 32'h13) begin
            n_fail++; $display("FAIL one_retry_status: got %h want 13", d);
        end
        if (ok_cyc[0] != 11) begin
            n_fail++; $display("FAIL one_retry_ok_cycle: got %0d want 11", ok_cyc[0]);
        end
        if (rd_n[0] != 4 || rd_cyc[0][2] != 6) begin
            n_fail++;
            $display("FAIL one_retry_reads: got %0d reads, 3rd at %0d want 4 / 6", rd_n[0],
                     rd_cyc[0][2]);
        end
        n_resp[0] = 0;
    endtask

    task automatic test_random();
        logic [31:0] d, cid, cts;
        int          retr, done_c, L, g, nbad, sel, exp_c;
        bit          pass;
        for (int it = 0; it < 8; it++) begin
            g    = $urandom_range(0, 2);
            L    = lat_of(g);
            nbad = $urandom_range(0, 5);
            for (int p = 0; p < 8; p++) begin
                sel           = $urandom_range(0, 2);
                id_resp[g][p] = (sel != 1) ? ($urandom | 32'h1) : EXP_ID;
                ts_resp[g][p] = (sel != 0) ? (EXP_TS ^ ($urandom | 32'h1)) : EXP_TS;
            end
            n_resp[g] = nbad;
            predict(g, retr, pass, done_c, cid, cts);
            start(g);
            wait_until(g, done_c + 2);
            slave_read(g, 2'd0, d);
            n_cmp += 2;
            if (d !== {24'd0, 4'(retr), 2'b00, pass, 1'b1}) begin
                n_fail++;
                $display("FAIL rand_status it%0d dut%0d: got %h want %h", it, g, d,
                         {24'd0, 4'(retr), 2'b00, pass, 1'b1});
            end
            if (ok_cyc[g] != (pass ? done_c : -1)) begin
                n_fail++;
                $display("FAIL rand_ok_cycle it%0d dut%0d: got %0d want %0d", it, g, ok_cyc[g],
                         pass ? done_c : -1);
            end
            n_cmp++;
            if (rd_n[g] != 2 * (retr + 1)) begin
                n_fail++;
                $display("FAIL rand_reads it%0d dut%0d: got %0d want %0d", it, g, rd_n[g],
                         2 * (retr + 1));
            end
            for (int k = 0; k < 2 * (retr + 1) && k < 16; k++) begin
                exp_c = 1 + (k / 2) * (3 + 2 * L) + (k % 2) * (1 + L);
                n_cmp++;
                if (rd_cyc[g][k] != exp_c || rd_adr[g][k] !== 1'(k % 2)) begin
                    n_fail++;
                    $display("FAIL rand_read_slot it%0d dut%0d k%0d: got %0d/%b want %0d/%0d",
                             it, g, k, rd_cyc[g][k], rd_adr[g][k], exp_c, k % 2);
                end
            end
            slave_read(g, 2'd1, d);
            n_cmp++;
            if (d !== cid) begin
                n_fail++; $display("FAIL rand_cap_id it%0d dut%0d: got %h want %h", it, g, d, cid);
            end
            slave_read(g, 2'd2, d);
            n_cmp++;
            if (d !== cts) begin
                n_fail++; $display("FAIL rand_cap_ts it%0d dut%0d: got %h want %h", it, g, d, cts);
            end
            n_resp[g] = 0;
        end
    endtask

    task automatic test_restart();
        logic [31:0] d;
        int          t;
        n_resp[0] = 0;
        start(0);
        wait_until(0, 2);
        slave_write(0, 2'd3, 32'h1);
        wait_until(0, 9);
        slave_write(0, 2'd0, 32'h1);
        slave_write(0, 2'd3, 32'h2);
        repeat (3) @(posedge clk);
        #1;
        n_cmp += 2;
        if (rd_n[0] != 2) begin
            n_fail++; $display("FAIL restart_ignored: got %0d reads want 2", rd_n[0]);
        end
        if (ok[0] !== 1'b1) begin
            n_fail++; $display("FAIL restart_pre_ok: got %b want 1", ok[0]);
        end
        t = cyc[0] + 1;
        slave_write(0, 2'd3, 32'h1);
        n_cmp++;
        if (ok[0] !== 1'b0) begin
            n_fail++; $display("FAIL restart_ok_drop: got %b want 0", ok[0]);
        end
        slave_read(0, 2'd0, d);
        n_cmp++;
        if (d !== 32'h4) begin
            n_fail++; $display("FAIL restart_status_busy: got %h want 4", d);
        end
        wait_until(0, t + 1 + 6 + 2);
        slave_read(0, 2'd0, d);
        n_cmp += 3;
        if (d !== 32'h3) begin
            n_fail++; $display("FAIL restart_status_done: got %h want 3", d);
        end
        if (rd_n[0] != 4 || rd_cyc[0][2] != t + 1 || rd_cyc[0][3] != t + 3) begin
            n_fail++;
            $display("FAIL restart_reads: got %0d reads at %0d,%0d want 4 at %0d,%0d", rd_n[0],
                     rd_cyc[0][2], rd_cyc[0][3], t + 1, t + 3);
        end
        if (ok[0] !== 1'b1) begin
            n_fail++; $display("FAIL restart_ok_again: got %b want 1", ok[0]);
        end
    endtask

    // A status read in the CMP cycle sees the pre-update word, and the value then holds.
    task automatic test_read_timing();
        logic [31:0] d;
        start(0);
        wait_until(0, 5);
        slave_read(0, 2'd0, d);
        n_cmp += 2;
        if (d !== 32'h4) begin
            n_fail++; $display("FAIL cmp_cycle_status: got %h want 4", d);
        end
        repeat (3) @(posedge clk);
        #1;
        if (rdata[0] !== 32'h4) begin
            n_fail++; $display("FAIL readdata_hold: got %h want 4", rdata[0]);
        end
        slave_read(0, 2'd0, d);
        n_cmp++;
        if (d !== 32'h3) begin
            n_fail++; $display("FAIL status_after_hold: got %h want 3", d);
        end
    endtask

    task automatic test_midread_reset();
        logic [31:0] d;
        start(0);
        wait_until(0, 2);
        slave_read(0, 2'd0, d);
        wait_until(0, 4);
        n_cmp++;
        if (rdata[0] !== 32'h4) begin
            n_fail++; $display("FAIL midreset_pre_readdata: got %h want 4", rdata[0]);
        end
        rst_n[0] = 1'b0;
        @(posedge clk);
        #1;
        n_cmp += 4;
        if (mrd[0] !== 1'b0) begin
            n_fail++; $display("FAIL midreset_m_read: got %b want 0", mrd[0]);
        end
        if (madr[0] !== 1'b0) begin
            n_fail++; $display("FAIL midreset_m_address: got %b want 0", madr[0]);
        end
        if (rdata[0] !== 32'd0) begin
            n_fail++; $display("FAIL midreset_s_readdata: got %h want 0", rdata[0]);
        end
        if (ok[0] !== 1'b0) begin
            n_fail++; $display("FAIL midreset_sysid_ok: got %b want 0", ok[0]);
        end
        start(0);
        slave_read(0, 2'd2, d);
        n_cmp++;
        if (d !== 32'd0) begin
            n_fail++; $display("FAIL midreset_cap_ts_cleared: got %h want 0", d);
        end
        wait_until(0, 8);
        slave_read(0, 2'd0, d);
        n_cmp += 3;
        if (d !== 32'h3) begin
            n_fail++; $display("FAIL midreset_rerun_status: got %h want 3", d);
        end
        if (ok_cyc[0] != 6) begin
            n_fail++; $display("FAIL midreset_rerun_ok_cycle: got %0d want 6", ok_cyc[0]);
        end
        if (rd_n[0] != 2 || rd_cyc[0][0] != 1 || rd_cyc[0][1] != 3) begin
            n_fail++;
            $display("FAIL midreset_rerun_reads: got %0d at %0d,%0d want 2 at 1,3", rd_n[0],
                     rd_cyc[0][0], rd_cyc[0][1]);
        end
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin
            rst_n[g]  = 1'b0;
            s_rd[g]   = 1'b0;
            s_wr[g]   = 1'b0;
            s_addr[g] = 2'd0;
            s_wd[g]   = 32'd0;
            n_resp[g] = 0;
        end
        test_reset();
        test_first_pass();
        test_retry_exhaust();
        test_one_retry();
        test_random();
        test_restart();
        test_read_timing();
        test_midread_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
